// File: rtl/video_pkg.sv
// Shared definitions for the video write queue: address regions, queued entry layout
// and the field positions of the CPU status word.
package video_pkg;

   localparam logic [3:0] VID_REGION_REG    = 4'h0;
   localparam logic [3:0] VID_REGION_TEX    = 4'h1;
   localparam logic [3:0] VID_REGION_TILE   = 4'h2;
   localparam logic [3:0] VID_REGION_SPRITE = 4'h3;

   // Status word: {frame_count[15:0], full, empty, 6'b0, count[7:0]}
   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_EMPTY_BIT = 14;
   localparam int STAT_FULL_BIT  = 15;
   localparam int STAT_FRAME_LSB = 16;

   localparam int ENTRY_W = 60;

   typedef struct packed {
      logic [3:0]  wstrb;
      logic [23:0] addr;
      logic [31:0] wdata;
   } vid_entry_t;

   function automatic logic is_reg_region(input logic [23:0] addr);
      return addr[23:20] == VID_REGION_REG;
   endfunction

endpackage

// File: rtl/video_wq_fifo.sv
// Synchronous in-order FIFO of queued video writes; asynchronous head read so the
// drain logic can inspect the next entry's address in the same cycle.
module video_wq_fifo
   import video_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  vid_entry_t       din_i,
   input  logic             pop_i,
   output vid_entry_t       dout_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   vid_entry_t       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage carries no reset so it can map onto RAM primitives.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/video_write_queue.sv
// CPU-side write buffer for the video block: register writes wait for vertical blank so a
// frame sees one consistent register set; memory writes drain as soon as they reach the head.
module video_write_queue
   import video_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter bit IMMEDIATE_REGS = 1'b0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        vblank,
   output logic        out_valid,
   output logic [3:0]  out_wstrb,
   output logic [31:0] out_addr,
   output logic [31:0] out_wdata
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             vblank_q;
   logic [15:0]      frame_q;
   logic             out_valid_q;
   vid_entry_t       out_q;

   logic             take, is_wr, push, rd_take, pop;
   vid_entry_t       din, head;
   logic [CNT_W-1:0] count;
   logic             full, empty;
   logic [31:0]      status;
   logic             unused_addr_hi;

   assign unused_addr_hi = ^iomem_addr[31:24];

   // A request is only sampled while ready is low, so ready never stays up two cycles.
   assign take    = iomem_valid && !ready_q;
   assign is_wr   = |iomem_wstrb;
   assign push    = take && is_wr && !full;
   assign rd_take = take && !is_wr;
   assign din     = '{wstrb: iomem_wstrb, addr: iomem_addr[23:0], wdata: iomem_wdata};
   assign pop     = !empty && (!is_reg_region(head.addr) || vblank || IMMEDIATE_REGS);

   video_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (push),
      .din_i   (din),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      status                          = '0;
      status[STAT_FRAME_LSB +: 16]    = frame_q;
      status[STAT_FULL_BIT]           = full;
      status[STAT_EMPTY_BIT]          = empty;
      status[STAT_COUNT_LSB +: 8]     = 8'(count);
      ready_d                         = push || rd_take;
      rdata_d                         = rd_take ? status : '0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         vblank_q    <= 1'b0;
         frame_q     <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         vblank_q    <= vblank;
         if (vblank && !vblank_q) frame_q <= frame_q + 1'b1;
         out_valid_q <= pop;
         if (pop) out_q <= head;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign out_valid   = out_valid_q;
   assign out_wstrb   = out_q.wstrb;
   assign out_addr    = {8'h00, out_q.addr};
   assign out_wdata   = out_q.wdata;

endmodule

// File: tb/tb_video_write_queue.sv
// Self-checking bench for video_write_queue: directed scenarios plus a randomized
// stream compared against an in-order queue model with a vblank gating check.
module tb_video_write_queue;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = '0;
   logic [31:0] iomem_addr = '0;
   logic [31:0] iomem_wdata = '0;
   logic [31:0] iomem_rdata;
   logic        vblank = 1'b0;
   logic        out_valid;
   logic [3:0]  out_wstrb;
   logic [31:0] out_addr;
   logic [31:0] out_wdata;

   video_write_queue #(.DEPTH(DEPTH), .IMMEDIATE_REGS(1'b0)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .vblank      (vblank),
      .out_valid   (out_valid),
      .out_wstrb   (out_wstrb),
      .out_addr    (out_addr),
      .out_wdata   (out_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          cyc;
   } wr_t;

   int  vectors = 0, errors = 0, cyc = 0, gate_err = 0, exp_frame = 0;
   bit  last_vb = 1'b0;
   bit  stop_vb = 1'b0;
   wr_t got[$], exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: collect emitted writes; a register write may only leave while vblank was high.
   always @(negedge clk) begin
      if (resetn && out_valid) begin
         got.push_back('{out_addr, out_wdata, out_wstrb, cyc});
         if (out_addr[23:20] == 4'h0 && !last_vb) gate_err++;
      end
      last_vb = vblank;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_vb(input bit v);
      if (v && !vblank) exp_frame++;
      vblank = v;
   endtask

   task automatic apply_reset(input int n);
      resetn = 1'b0; iomem_valid = 1'b0; vblank = 1'b0;
      step(n);
      resetn = 1'b1;
      got.delete(); exp_q.delete(); exp_frame = 0; gate_err = 0;
   endtask

   task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      iomem_addr = a; iomem_wdata = d; iomem_wstrb = s; iomem_valid = 1'b1;
   endtask

   task automatic wait_ready(input int bound, output int rcyc, output logic [31:0] rd,
                             output bit ok);
      ok = 1'b0; rcyc = 0; rd = '0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (iomem_ready) begin ok = 1'b1; rcyc = cyc; rd = iomem_rdata; break; end
      end
      @(posedge clk); #1;
      iomem_valid = 1'b0;
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL ready_timeout: got no ready, expected ready within %0d cycles", bound);
      end else begin
         @(negedge clk);
         if (iomem_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_one_cycle: got ready=%b, expected 0", iomem_ready);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int waited, output int rcyc);
      int c0; logic [31:0] rd; bit ok;
      c0 = cyc;
      start_req(a, d, s);
      wait_ready(200, rcyc, rd, ok);
      waited = rcyc - c0;
      if (ok) exp_q.push_back('{{8'h00, a[23:0]}, d, s, 0});
   endtask

   task automatic cpu_read(output logic [31:0] rd);
      int rc; bit ok;
      start_req(32'h0, 32'h0, 4'h0);
      wait_ready(200, rc, rd, ok);
   endtask

   task automatic check_drain(input string tag);
      int n;
      vectors++;
      if (got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d writes, expected %0d", tag, got.size(), exp_q.size());
      end
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data ||
             got[i].strb !== exp_q[i].strb) begin
            errors++;
            $display("FAIL %s_entry%0d: got %h/%h/%h, expected %h/%h/%h", tag, i,
                     got[i].addr, got[i].data, got[i].strb,
                     exp_q[i].addr, exp_q[i].data, exp_q[i].strb);
         end
      end
      vectors++;
      if (gate_err != 0) begin
         errors++;
         $display("FAIL %s_gating: got %0d register writes outside vblank, expected 0",
                  tag, gate_err);
      end
      got.delete(); exp_q.delete(); gate_err = 0;
   endtask

   function automatic logic [31:0] status_word(input int frame, input bit full, input bit empty,
                                               input int cnt);
      logic [15:0] f; logic [7:0] c;
      f = frame[15:0]; c = cnt[7:0];
      return {f, full, empty, 6'b0, c};
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      resetn = 1'b0;
      step(3);
      @(negedge clk);
      vectors++;
      if ({out_valid, iomem_ready, iomem_rdata, out_addr, out_wdata, out_wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b r=%b rd=%h a=%h d=%h s=%h, expected all 0",
                  out_valid, iomem_ready, iomem_rdata, out_addr, out_wdata, out_wstrb);
      end
      @(posedge clk); #1;
      apply_reset(1);
      cpu_read(rd);
      vectors++;
      if (rd !== status_word(0, 0, 1, 0)) begin
         errors++;
         $display("FAIL reset_status: got %h, expected %h", rd, status_word(0, 0, 1, 0));
      end
   endtask

   task automatic test_reg_gated();
      int w, rc;
      set_vb(0);
      cpu_write(32'h0500_0000, 32'h10, 4'hF, w, rc);
      vectors++;
      if (w !== 1) begin
         errors++;
         $display("FAIL reg_ready_latency: got %0d cycles, expected 1", w);
      end
      step(6);
      vectors++;
      if (got.size() != 0) begin
         errors++;
         $display("FAIL reg_held: got %0d writes before vblank, expected 0", got.size());
      end
      set_vb(1); step(3); set_vb(0);
      check_drain("reg_gated");
   endtask

   task automatic test_mem_latency();
      int w, rc, lat;
      cpu_write(32'h0510_0008, 32'h5, 4'hF, w, rc);
      step(4);
      lat = (got.size() > 0) ? got[0].cyc - rc : -1;
      vectors++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL mem_latency: got out_valid %0d cycles after ready, expected 1", lat);
      end
      check_drain("mem_latency");
   endtask

   task automatic test_order();
      int w, rc, gap;
      set_vb(0);
      cpu_write(32'h0000_0004, 32'hA1, 4'hF, w, rc);
      cpu_write(32'h0020_0010, 32'hB2, 4'h3, w, rc);
      step(5);
      vectors++;
      if (got.size() != 0) begin
         errors++;
         $display("FAIL order_hold: got %0d writes before vblank, expected 0", got.size());
      end
      set_vb(1); step(4); set_vb(0);
      gap = (got.size() == 2) ? got[1].cyc - got[0].cyc : -1;
      vectors++;
      if (gap !== 1) begin
         errors++;
         $display("FAIL order_consecutive: got gap %0d, expected 1", gap);
      end
      check_drain("order");
   endtask

   task automatic test_full();
      int w, rc; logic [31:0] rd; bit ok, stalled_ok;
      set_vb(0);
      for (int i = 0; i < DEPTH; i++) cpu_write(32'h0400_0000 + 32'(i * 4), 32'(i), 4'hF, w, rc);
      cpu_read(rd);
      vectors++;
      if (rd !== status_word(exp_frame, 1, 0, DEPTH)) begin
         errors++;
         $display("FAIL full_status: got %h, expected %h", rd, status_word(exp_frame, 1, 0, DEPTH));
      end
      start_req(32'h0000_0100, 32'hDEAD_0017, 4'hF);
      stalled_ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (iomem_ready !== 1'b0) stalled_ok = 1'b0;
      end
      vectors++;
      if (!stalled_ok) begin
         errors++;
         $display("FAIL full_stall: got ready=1 while full, expected 0");
      end
      @(posedge clk); #1;
      set_vb(1);
      wait_ready(50, rc, rd, ok);
      if (ok) exp_q.push_back('{32'h0000_0100, 32'hDEAD_0017, 4'hF, 0});
      step(24); set_vb(0);
      check_drain("full");
   endtask

   task automatic test_frames();
      logic [31:0] rd;
      apply_reset(2);
      repeat (3) begin
         set_vb(1); step(2); set_vb(0); step(2);
      end
      cpu_read(rd);
      vectors++;
      if (rd !== status_word(3, 0, 1, 0)) begin
         errors++;
         $display("FAIL frame_count: got %h, expected %h", rd, status_word(3, 0, 1, 0));
      end
   endtask

   task automatic test_reset_flush();
      int w, rc; logic [31:0] rd;
      set_vb(0);
      for (int i = 0; i < 5; i++) cpu_write(32'h0000_0040 + 32'(i * 4), 32'h100 + 32'(i), 4'hF, w, rc);
      apply_reset(1);
      cpu_read(rd);
      vectors++;
      if (rd !== status_word(0, 0, 1, 0)) begin
         errors++;
         $display("FAIL flush_status: got %h, expected %h", rd, status_word(0, 0, 1, 0));
      end
      set_vb(1); step(10); set_vb(0);
      vectors++;
      if (got.size() != 0) begin
         errors++;
         $display("FAIL flush_replay: got %0d writes after reset, expected 0", got.size());
      end
      got.delete();
   endtask

   task automatic test_random();
      int w, rc, cnt; logic [31:0] rd, a; logic [3:0] region;
      stop_vb = 1'b0;
      fork
         begin
            while (!stop_vb) begin
               step($urandom_range(3, 12));
               if (!stop_vb) set_vb(!vblank);
            end
         end
      join_none
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cpu_read(rd);
            cnt = int'(rd[7:0]);
            vectors++;
            if (cnt > DEPTH || rd[15] !== (cnt == DEPTH) || rd[14] !== (cnt == 0) ||
                rd[13:8] !== 6'b0) begin
               errors++;
               $display("FAIL rand_status: got %h, expected consistent full/empty/count", rd);
            end
         end else begin
            region = 4'($urandom_range(0, 3));
            a = {8'($urandom), region, 20'($urandom)};
            cpu_write(a, $urandom, 4'($urandom_range(1, 15)), w, rc);
         end
         step($urandom_range(0, 3));
      end
      stop_vb = 1'b1;
      step(16);
      set_vb(1); step(40);
      cpu_read(rd);
      vectors++;
      if (rd !== status_word(exp_frame, 0, 1, 0)) begin
         errors++;
         $display("FAIL rand_final_status: got %h, expected %h", rd, status_word(exp_frame, 0, 1, 0));
      end
      set_vb(0);
      check_drain("random");
   endtask

   initial begin
      test_reset();
      test_reg_gated();
      test_mem_latency();
      test_order();
      test_full();
      test_frames();
      test_reset_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion, expected finish");
      $fatal(1);
   end

endmodule
